seq_stream_ctrl: RTL and testbench

SEQ_STREAM_CTRL -- requirements
Module: seq_stream_ctrl

---
 rtl/seq_pkg.sv | 7 +
 rtl/seq_stream_ctrl_if.sv | 15 +
 rtl/seq_shifter.sv | 36 +++
 rtl/seq_stream_ctrl.sv | 75 +++++++
 tb/tb_seq_stream_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and constants for the sequence stream controller
package seq_pkg;
    localparam int MAX_LEN = 16;
    localparam int DRAIN_CYC = 2;
    localparam logic [3:0] FIRST_NONE = 4'hF;
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DRAIN, DONE} state_t;
endpackage

// File: rtl/seq_stream_ctrl_if.sv
// seq_stream_ctrl_if: burst request, detector link and result signals
interface seq_stream_ctrl_if;
    logic        start;
    logic [15:0] data;
    logic [4:0]  len;
    logic        det_flag;
    logic        det_din;
    logic        det_rst;
    logic        busy;
    logic        done;
    logic [4:0]  hit_cnt;
    logic [3:0]  first_hit;
    modport master (output start, data, len, det_flag, input det_din, det_rst, busy, done, hit_cnt, first_hit);
    modport slave  (input start, data, len, det_flag, output det_din, det_rst, busy, done, hit_cnt, first_hit);
endinterface

// File: rtl/seq_shifter.sv
// seq_shifter: burst data register, bit-index counter and registered serial bit mux
module seq_shifter #(
    parameter int W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_load,
    input  logic                   i_shift,
    input  logic [W-1:0]           i_data,
    input  logic [$clog2(W+1)-1:0] i_len_eff,
    output logic                   o_last,
    output logic                   o_din
);
    localparam int IW = $clog2(W);
    logic [W-1:0]  r_data;
    logic [IW-1:0] r_idx;
    logic          r_din;
    logic [W-1:0]  w_src;
    logic [IW-1:0] w_idx;
    // the first bit comes straight from the input so it is on the line in SHIFT cycle 0
    assign w_src  = i_load ? i_data : r_data;
    assign w_idx  = i_load ? IW'(i_len_eff) - IW'(1) : r_idx - IW'(1);
    assign o_last = r_idx == '0;
    assign o_din  = r_din;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_idx  <= '0;
            r_din  <= 1'b0;
        end else begin
            if (i_load) r_data <= i_data;
            if (i_shift) r_idx <= w_idx;
            r_din <= i_shift & w_src[w_idx];
        end
    end
endmodule

// File: rtl/seq_stream_ctrl.sv
// seq_stream_ctrl: serialises a captured burst into a sequence detector and tallies its hits
module seq_stream_ctrl #(
    parameter int MAX_LEN   = 16,
    parameter int DRAIN_CYC = 2
) (
    input logic              clk,
    input logic              rst_n,
    seq_stream_ctrl_if.slave bus
);
    import seq_pkg::*;
    localparam logic [5:0] DC = 6'(DRAIN_CYC);
    state_t     r_state, w_next;
    logic [4:0] r_len, r_hit, w_len_eff;
    logic [5:0] r_cyc;
    logic [3:0] r_first, w_k;
    logic       r_det_rst, r_busy, r_done, w_last, w_win, w_end;
    assign w_len_eff = (bus.len > 5'(MAX_LEN)) ? 5'(MAX_LEN) : bus.len;
    // r_cyc counts from SHIFT cycle 0; the detector flag lags its bit by DRAIN_CYC cycles
    assign w_win = (r_state == SHIFT || r_state == DRAIN) && r_cyc >= DC;
    assign w_k   = 4'(r_cyc - DC);
    assign w_end = r_cyc == {1'b0, r_len} + DC - 6'd1;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? LOAD : IDLE;
            LOAD:    w_next = (w_len_eff == '0) ? DONE : SHIFT;
            SHIFT:   w_next = w_last ? DRAIN : SHIFT;
            DRAIN:   w_next = w_end ? DONE : DRAIN;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end
    seq_shifter #(.W(MAX_LEN)) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (r_state == LOAD),
        .i_shift   (w_next == SHIFT),
        .i_data    (bus.data),
        .i_len_eff (w_len_eff),
        .o_last    (w_last),
        .o_din     (bus.det_din)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_det_rst <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hit     <= '0;
            r_first   <= FIRST_NONE;
            r_len     <= '0;
            r_cyc     <= '0;
        end else begin
            r_det_rst <= !(w_next == SHIFT || w_next == DRAIN);
            r_busy    <= w_next == LOAD || w_next == SHIFT || w_next == DRAIN;
            r_done    <= w_next == DONE;
            r_cyc     <= (r_state == LOAD) ? '0 : r_cyc + 6'd1;
            if (r_state == LOAD) r_len <= w_len_eff;
            if (w_next == LOAD) begin
                r_hit   <= '0;
                r_first <= FIRST_NONE;
            end else if (w_win && bus.det_flag) begin
                r_hit <= (r_hit == 5'd31) ? r_hit : r_hit + 5'd1;
                if (r_hit == '0) r_first <= w_k;
            end
        end
    end
    assign bus.det_rst   = r_det_rst;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.hit_cnt   = r_hit;
    assign bus.first_hit = r_first;
endmodule

// File: tb/tb_seq_stream_ctrl.sv
// tb_seq_stream_ctrl: directed and randomized bursts against an 01010101 detector and a bit-array model
module tb_seq_stream_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, force_flag = 1'b0;
    int total = 0, bad = 0;
    seq_stream_ctrl_if bus();
    seq_stream_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    // reference detector: overlapping 01010101, flag two registers after the bit
    logic [7:0] sr = '0;
    logic m = 1'b0, f = 1'b0;
    int nb = 0;
    always @(posedge clk) begin
        if (bus.det_rst) begin
            sr <= '0; m <= 1'b0; f <= 1'b0; nb <= 0;
        end else begin
            sr <= {sr[6:0], bus.det_din};
            m  <= (nb >= 7) && ({sr[6:0], bus.det_din} == 8'h55);
            f  <= m;
            nb <= nb + 1;
        end
    end
    assign bus.det_flag = force_flag | f;

    int n_done, n_rstlo, n_busy;
    logic [4:0] hit_d, hit_h;
    logic [3:0] first_d, first_h;
    logic busy_h;

    // caller is just past a negedge; n counts negedges after the accepting edge
    task automatic run_burst(input logic [15:0] d, input logic [4:0] l, input bit scramble, input bit poke);
        bus.start = 1'b1; bus.data = d; bus.len = l;
        n_done = 0; n_rstlo = 0; n_busy = 0;
        @(posedge clk);
        for (int n = 1; n <= 100 && n_done == 0; n++) begin
            @(negedge clk);
            bus.start = poke && (n == 3);
            if (bus.det_rst === 1'b0) n_rstlo++;
            if (bus.busy === 1'b1) n_busy++;
            if (bus.done === 1'b1) begin
                n_done = n; hit_d = bus.hit_cnt; first_d = bus.first_hit;
            end
            if (scramble && n >= 2) begin
                bus.data = 16'($urandom); bus.len = 5'($urandom);
            end
        end
        bus.start = poke;
        @(negedge clk);
        hit_h = bus.hit_cnt; first_h = bus.first_hit; busy_h = bus.busy;
        bus.start = 1'b0;
    endtask

    function automatic int model_hits(input logic [15:0] d, input int l, output int first);
        bit b [16];
        int len_e, h;
        len_e = (l > 16) ? 16 : l; h = 0; first = 15;
        for (int i = 0; i < len_e; i++) b[i] = d[len_e-1-i];
        for (int k = 7; k < len_e; k++) begin
            bit ok;
            ok = 1'b1;
            for (int j = 0; j < 8; j++) if (b[k-j] != bit'(j % 2 == 0)) ok = 1'b0;
            if (ok) begin
                if (h == 0) first = k;
                h++;
            end
        end
        return h;
    endfunction

    task automatic test_reset;
        if (bus.det_rst !== 1'b1) begin bad++; $display("FAIL reset_det_rst got=%b exp=1", bus.det_rst); end total++;
        if (bus.det_din !== 1'b0) begin bad++; $display("FAIL reset_det_din got=%b exp=0", bus.det_din); end total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end total++;
        if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end total++;
        if (bus.hit_cnt !== 5'd0) begin bad++; $display("FAIL reset_hit got=%0d exp=0", bus.hit_cnt); end total++;
        if (bus.first_hit !== 4'hF) begin bad++; $display("FAIL reset_first got=%h exp=f", bus.first_hit); end total++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_pattern;
        logic [15:0] td [2] = '{16'h0055, 16'h0155};
        logic [4:0]  tl [2] = '{5'd8, 5'd10};
        int eh [2] = '{1, 2};
        int ed [2] = '{12, 14};
        for (int c = 0; c < 2; c++) begin
            run_burst(td[c], tl[c], 1'b0, 1'b0);
            if (hit_d !== 5'(eh[c])) begin bad++; $display("FAIL pat%0d_hits got=%0d exp=%0d", c, hit_d, eh[c]); end total++;
            if (first_d !== 4'd7) begin bad++; $display("FAIL pat%0d_first got=%0d exp=7", c, first_d); end total++;
            if (n_done != ed[c]) begin bad++; $display("FAIL pat%0d_done_at got=%0d exp=%0d", c, n_done, ed[c]); end total++;
            if (n_busy != ed[c] - 1) begin bad++; $display("FAIL pat%0d_busy_cycles got=%0d exp=%0d", c, n_busy, ed[c] - 1); end total++;
            if (hit_h !== 5'(eh[c])) begin bad++; $display("FAIL pat%0d_hit_hold got=%0d exp=%0d", c, hit_h, eh[c]); end total++;
        end
    endtask

    task automatic test_all_ones;
        run_burst(16'hFFFF, 5'd16, 1'b0, 1'b0);
        if (hit_d !== 5'd0) begin bad++; $display("FAIL ones_hits got=%0d exp=0", hit_d); end total++;
        if (first_d !== 4'hF) begin bad++; $display("FAIL ones_first got=%h exp=f", first_d); end total++;
        if (n_rstlo != 18) begin bad++; $display("FAIL ones_det_rst_low got=%0d exp=18", n_rstlo); end total++;
        if (n_done != 20) begin bad++; $display("FAIL ones_done_at got=%0d exp=20", n_done); end total++;
    endtask

    task automatic test_len_bounds;
        run_burst(16'hFFFF, 5'd0, 1'b0, 1'b0);
        if (n_done != 2) begin bad++; $display("FAIL len0_done_at got=%0d exp=2", n_done); end total++;
        if (n_rstlo != 0) begin bad++; $display("FAIL len0_shift_cycles got=%0d exp=0", n_rstlo); end total++;
        if (n_busy != 1) begin bad++; $display("FAIL len0_busy_cycles got=%0d exp=1", n_busy); end total++;
        if (hit_d !== 5'd0) begin bad++; $display("FAIL len0_hits got=%0d exp=0", hit_d); end total++;
        if (first_d !== 4'hF) begin bad++; $display("FAIL len0_first got=%h exp=f", first_d); end total++;
        run_burst(16'h5555, 5'd20, 1'b0, 1'b0);
        if (n_done != 20) begin bad++; $display("FAIL len20_done_at got=%0d exp=20", n_done); end total++;
        if (n_rstlo != 18) begin bad++; $display("FAIL len20_det_rst_low got=%0d exp=18", n_rstlo); end total++;
        if (hit_d !== 5'd5) begin bad++; $display("FAIL len20_hits got=%0d exp=5", hit_d); end total++;
        if (first_d !== 4'd7) begin bad++; $display("FAIL len20_first got=%0d exp=7", first_d); end total++;
    endtask

    task automatic test_stale_flag;
        force_flag = 1'b1;
        run_burst(16'h0000, 5'd4, 1'b0, 1'b0);
        force_flag = 1'b0;
        if (hit_d !== 5'd4) begin bad++; $display("FAIL stale_hits got=%0d exp=4", hit_d); end total++;
        if (first_d !== 4'd0) begin bad++; $display("FAIL stale_first got=%0d exp=0", first_d); end total++;
        if (n_done != 8) begin bad++; $display("FAIL stale_done_at got=%0d exp=8", n_done); end total++;
    endtask

    task automatic test_start_ignored;
        run_burst(16'h0155, 5'd10, 1'b0, 1'b1);
        if (n_done != 14) begin bad++; $display("FAIL ign_done_at got=%0d exp=14", n_done); end total++;
        if (hit_d !== 5'd2) begin bad++; $display("FAIL ign_hits got=%0d exp=2", hit_d); end total++;
        if (busy_h !== 1'b0) begin bad++; $display("FAIL ign_restart_busy got=%b exp=0", busy_h); end total++;
        if (hit_h !== 5'd2) begin bad++; $display("FAIL ign_hit_hold got=%0d exp=2", hit_h); end total++;
    endtask

    task automatic test_random;
        for (int t = 0; t < 40; t++) begin
            logic [15:0] d;
            logic [4:0] l;
            int eh, ef, le, ed;
            d = ($urandom_range(0, 1) == 1) ? (16'h5555 ^ (16'd1 << $urandom_range(0, 15))) : 16'($urandom);
            l = 5'($urandom_range(0, 31));
            eh = model_hits(d, int'(l), ef);
            le = (l > 16) ? 16 : int'(l);
            ed = (le == 0) ? 2 : le + 4;
            run_burst(d, l, 1'b1, 1'b0);
            if (hit_d !== 5'(eh)) begin bad++; $display("FAIL rand%0d_hits d=%h l=%0d got=%0d exp=%0d", t, d, l, hit_d, eh); end total++;
            if (first_d !== 4'(ef)) begin bad++; $display("FAIL rand%0d_first d=%h l=%0d got=%0d exp=%0d", t, d, l, first_d, ef); end total++;
            if (n_done != ed) begin bad++; $display("FAIL rand%0d_done_at l=%0d got=%0d exp=%0d", t, l, n_done, ed); end total++;
            if (n_rstlo != ((le == 0) ? 0 : le + 2)) begin bad++; $display("FAIL rand%0d_det_rst_low l=%0d got=%0d", t, l, n_rstlo); end total++;
            if (first_h !== 4'(ef)) begin bad++; $display("FAIL rand%0d_first_hold got=%0d exp=%0d", t, first_h, ef); end total++;
        end
    endtask

    task automatic test_reset_mid;
        bus.start = 1'b1; bus.data = 16'hABCD; bus.len = 5'd16;
        @(posedge clk);
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", bus.busy); end total++;
        #2 rst_n = 1'b0;
        #1;
        if (bus.det_rst !== 1'b1) begin bad++; $display("FAIL mid_det_rst got=%b exp=1", bus.det_rst); end total++;
        if (bus.det_din !== 1'b0) begin bad++; $display("FAIL mid_det_din got=%b exp=0", bus.det_din); end total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end total++;
        if (bus.hit_cnt !== 5'd0) begin bad++; $display("FAIL mid_hit got=%0d exp=0", bus.hit_cnt); end total++;
        if (bus.first_hit !== 4'hF) begin bad++; $display("FAIL mid_first got=%h exp=f", bus.first_hit); end total++;
        if (dut.u_shift.r_data !== 16'h0) begin bad++; $display("FAIL mid_data_reg got=%h exp=0", dut.u_shift.r_data); end total++;
        @(negedge clk);
        rst_n = 1'b1;
        run_burst(16'h0055, 5'd8, 1'b0, 1'b0);
        if (n_done != 12) begin bad++; $display("FAIL post_rst_done_at got=%0d exp=12", n_done); end total++;
        if (hit_d !== 5'd1) begin bad++; $display("FAIL post_rst_hits got=%0d exp=1", hit_d); end total++;
        if (first_d !== 4'd7) begin bad++; $display("FAIL post_rst_first got=%0d exp=7", first_d); end total++;
    endtask

    initial begin
        bus.start = 1'b0; bus.data = '0; bus.len = '0;
        #12;
        test_reset;
        test_pattern;
        test_all_ones;
        test_len_bounds;
        test_stale_flag;
        test_start_ignored;
        test_random;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
